// File: rtl/alu_share_arb.sv
// Round-robin front end that shares one external combinational ALU between NREQ requesters.
// A granted request is registered onto the ALU inputs. The result is captured one cycle later
// and returned as a one-cycle pulse tagged with the requester id.
module alu_share_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned OPW  = 5,
  parameter int unsigned IDW  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ*OPW-1:0]  req_op,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [OPW-1:0]       alu_op,
  input  logic [31:0]          alu_c,
  output logic [NREQ-1:0]      resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          resp_c,
  output logic                 busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned PW = IDW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;
  logic [OPW-1:0]  alu_op_q, alu_op_d;
  logic [DW-1:0]   resp_c_q, resp_c_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;

  logic            grant_vld;
  logic [IDW-1:0]  winner;
  logic [PW-1:0]   scan_idx;
  logic [DW-1:0]   sel_a, sel_b;
  logic [OPW-1:0]  sel_op;

  // Round-robin scan: first valid requester starting at rr_ptr, wrapping modulo NREQ.
  // The sum is one bit wider than the pointer so that it cannot overflow before the wrap subtract.
  always_comb begin
    grant_vld = 1'b0;
    winner    = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + PW'(k);
      if (scan_idx >= PW'(NREQ)) scan_idx = scan_idx - PW'(NREQ);
      for (int j = 0; j < NREQ; j++) begin
        if (!grant_vld && (scan_idx == PW'(j)) && req_valid[j]) begin
          grant_vld = 1'b1;
          winner    = IDW'(j);
        end
      end
    end
  end

  // Select the winner's operands and opcode from the packed request buses.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        sel_a  = req_a[DW*i +: DW];
        sel_b  = req_b[DW*i +: DW];
        sel_op = req_op[OPW*i +: OPW];
      end
    end
  end

  // Next-state and datapath-load logic. Grants are issued only from IDLE or RESP,
  // and never while reset is asserted.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    resp_c_d     = resp_c_q;
    resp_id_d    = resp_id_q;
    resp_valid_d = '0;
    req_ready    = '0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (grant_vld && rst_n) begin
          req_ready = NREQ'(1) << winner;
          alu_a_d   = sel_a;
          alu_b_d   = sel_b;
          alu_op_d  = sel_op;
          id_d      = winner;
          rr_ptr_d  = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
          state_d   = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        resp_c_d     = alu_c;
        resp_id_d    = id_q;
        resp_valid_d = NREQ'(1) << id_q;
        state_d      = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Arbitration pointer, ALU operand and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      id_q         <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      resp_c_q     <= '0;
      resp_id_q    <= '0;
      resp_valid_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      resp_c_q     <= resp_c_d;
      resp_id_q    <= resp_id_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign resp_c     = resp_c_q;
  assign resp_id    = resp_id_q;
  assign resp_valid = resp_valid_q;
  assign busy       = (state_q != S_IDLE);

endmodule
